// File: rtl/led_seq_pkg.sv
// Shared types and constants for the LED colour sequencer.
package led_seq_pkg;

    typedef enum logic [1:0] {
        ST_MANUAL = 2'd0,
        ST_AUTO   = 2'd1,
        ST_PAUSE  = 2'd2
    } state_t;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/led_sequencer_if.sv
// Board-side control inputs and LED-driver outputs of the colour sequencer.
interface led_sequencer_if #(
    parameter int WIDTH = 3
) ();
    logic             button;
    logic             dir;
    logic             mode;
    logic [WIDTH-1:0] color;
    logic             wrap;
    logic [1:0]       state;

    modport master (
        output button, dir, mode,
        input  color, wrap, state
    );

    modport slave (
        input  button, dir, mode,
        output color, wrap, state
    );
endinterface

// File: rtl/led_seq_prescaler.sv
// Auto-mode step timer: counts enabled cycles and ticks once every AUTO_DIV of them.
module led_seq_prescaler #(
    parameter int AUTO_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);
    localparam int PW = (AUTO_DIV > 1) ? $clog2(AUTO_DIV) : 1;
    localparam logic [PW-1:0] TC = PW'(AUTO_DIV - 1);

    logic [PW-1:0] cnt;

    // Disabled cycles hold the count so a paused sequence resumes mid-period.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == TC) ? '0 : cnt + 1'b1;
        end
    end

    assign tick = en && (cnt == TC);
endmodule

// File: rtl/led_sequencer.sv
// LED colour sequencer: manual, auto and paused stepping through MIN_CODE..MAX_CODE.
// Build option LED_SEQ_EDGE_EN: manual mode steps once per button press instead of per cycle held.
//
// state     | meaning
// ST_MANUAL | step while button is held (or once per press with LED_SEQ_EDGE_EN)
// ST_AUTO   | step on each prescaler tick; button press pauses
// ST_PAUSE  | colour and prescaler frozen; button press resumes
module led_sequencer
    import led_seq_pkg::*;
#(
    parameter int WIDTH    = 3,
    parameter int MIN_CODE = 1,
    parameter int MAX_CODE = 6,
    parameter int AUTO_DIV = 4
) (
    input logic          clk,
    input logic          rst,
    led_sequencer_if.slave bus
);
    localparam logic [WIDTH-1:0] MIN_C = WIDTH'(MIN_CODE);
    localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_CODE);

    state_t           st;
    logic [WIDTH-1:0] color;
    logic             wrap;
    logic             button_q;
    logic             btn_rise;
    logic             manual_step;
    logic             tick;
    logic             pre_en;
    logic             pre_clr;
    logic [WIDTH-1:0] step_color;
    logic             step_wrap;

    assign btn_rise = bus.button & ~button_q;

`ifdef LED_SEQ_EDGE_EN
    assign manual_step = btn_rise;
`else
    assign manual_step = bus.button;
`endif

    // A press or a mode change in AUTO takes the cycle, so the counter does not advance.
    assign pre_en  = (st == ST_AUTO) && bus.mode && !btn_rise;
    assign pre_clr = (st == ST_MANUAL) || !bus.mode;

    led_seq_prescaler #(
        .AUTO_DIV(AUTO_DIV)
    ) u_prescaler (
        .clk (clk),
        .rst (rst),
        .clr (pre_clr),
        .en  (pre_en),
        .tick(tick)
    );

    always_comb begin
        step_color = color;
        step_wrap  = 1'b0;
        if (bus.dir == DIR_DOWN) begin
            if (color == MIN_C) begin
                step_color = MAX_C;
                step_wrap  = 1'b1;
            end else begin
                step_color = color - 1'b1;
            end
        end else begin
            if (color == MAX_C) begin
                step_color = MIN_C;
                step_wrap  = 1'b1;
            end else begin
                step_color = color + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st       <= ST_MANUAL;
            color    <= MIN_C;
            wrap     <= 1'b0;
            button_q <= 1'b0;
        end else begin
            button_q <= bus.button;
            wrap     <= 1'b0;
            case (st)
                ST_MANUAL: begin
                    if (bus.mode) begin
                        st <= ST_AUTO;
                    end else if (manual_step) begin
                        color <= step_color;
                        wrap  <= step_wrap;
                    end
                end
                ST_AUTO: begin
                    if (!bus.mode) begin
                        st <= ST_MANUAL;
                    end else if (btn_rise) begin
                        st <= ST_PAUSE;
                    end else if (tick) begin
                        color <= step_color;
                        wrap  <= step_wrap;
                    end
                end
                ST_PAUSE: begin
                    if (!bus.mode) begin
                        st <= ST_MANUAL;
                    end else if (btn_rise) begin
                        st <= ST_AUTO;
                    end
                end
                default: st <= ST_MANUAL;
            endcase
        end
    end

    assign bus.color = color;
    assign bus.wrap  = wrap;
    assign bus.state = st;
endmodule

// File: tb/tb_led_sequencer.sv
// Directed bench for led_sequencer at default parameters (WIDTH=3, 1..6, AUTO_DIV=4).
module tb_led_sequencer;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    led_sequencer_if #(.WIDTH(3)) bus ();

    led_sequencer #(
        .WIDTH   (3),
        .MIN_CODE(1),
        .MAX_CODE(6),
        .AUTO_DIV(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic expect_out(input string tag, input int c, input int w, input int s);
        check_val({tag, "_color"}, int'(bus.color), c);
        check_val({tag, "_wrap"},  int'(bus.wrap),  w);
        check_val({tag, "_state"}, int'(bus.state), s);
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        bus.button = 1'b0;
        bus.mode   = 1'b0;
        bus.dir    = 1'b0;
        cyc();
        rst = 1'b0;
    endtask

    int up_seq[6]   = '{2, 3, 4, 5, 6, 1};
    int up_wrap[6]  = '{0, 0, 0, 0, 0, 1};

    initial begin
        n_checks = 0;
        n_fail   = 0;

        // Reset held two cycles with button and mode high.
        rst        = 1'b1;
        bus.button = 1'b1;
        bus.mode   = 1'b1;
        bus.dir    = 1'b0;
        cyc();
        expect_out("rst1", 1, 0, 0);
        cyc();
        expect_out("rst2", 1, 0, 0);
        rst = 1'b0;
        cyc();
        expect_out("rst_release_auto", 1, 0, 1);

`ifndef LED_SEQ_EDGE_EN
        // Manual up, level-stepped.
        do_reset();
        cyc();
        bus.button = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cyc();
            expect_out($sformatf("man_up%0d", i), up_seq[i], up_wrap[i], 0);
        end
        bus.button = 1'b0;
        cyc();
        expect_out("man_hold1", 1, 0, 0);
        cyc();
        expect_out("man_hold2", 1, 0, 0);
`else
        // Edge build: one step per press.
        do_reset();
        bus.button = 1'b1;
        cyc();
        expect_out("edge_first", 2, 0, 0);
        cycles(4);
        expect_out("edge_held", 2, 0, 0);
        bus.button = 1'b0;
        cyc();
        expect_out("edge_release", 2, 0, 0);
        bus.button = 1'b1;
        cyc();
        expect_out("edge_repress", 3, 0, 0);
        bus.button = 1'b0;
`endif

        // Manual down wrap from MIN.
        do_reset();
        bus.dir    = 1'b1;
        bus.button = 1'b1;
        cyc();
        expect_out("down_wrap", 6, 1, 0);
        bus.button = 1'b0;
        cyc();
        expect_out("down_after", 6, 0, 0);

        // Auto stepping from colour 1.
        do_reset();
        bus.mode = 1'b1;
        cyc();
        expect_out("auto_enter", 1, 0, 1);
        cycles(3);
        expect_out("auto_pre3", 1, 0, 1);
        cyc();
        expect_out("auto_step1", 2, 0, 1);
        cycles(4);
        expect_out("auto_step2", 3, 0, 1);

        // Pause with prescaler at 2, resume: step two cycles later.
        cycles(2);
        bus.button = 1'b1;
        cyc();
        expect_out("pause_enter", 3, 0, 2);
        cycles(10);
        expect_out("pause_frozen", 3, 0, 2);
        bus.button = 1'b0;
        cyc();
        bus.button = 1'b1;
        cyc();
        expect_out("resume", 3, 0, 1);
        bus.button = 1'b0;
        cyc();
        expect_out("resume_plus1", 3, 0, 1);
        cyc();
        expect_out("resume_plus2", 4, 0, 1);

        // Rise coinciding with terminal count: no step.
        cycles(3);
        bus.button = 1'b1;
        cyc();
        expect_out("rise_at_tc", 4, 0, 2);
        bus.button = 1'b0;
        cyc();
        bus.button = 1'b1;
        cyc();
        expect_out("resume_at_tc", 4, 0, 1);
        bus.button = 1'b0;
        cyc();
        expect_out("tc_step", 5, 0, 1);

        // Reset mid-AUTO with mode still high.
        rst = 1'b1;
        cyc();
        expect_out("mid_rst", 1, 0, 0);
        rst = 1'b0;
        cyc();
        expect_out("mid_rst_auto", 1, 0, 1);

        // Mode change beats a simultaneous button rise.
        bus.mode   = 1'b0;
        bus.button = 1'b1;
        cyc();
        expect_out("mode_beats_rise", 1, 0, 0);
        bus.button = 1'b0;
        cyc();

        // Auto wrap downward.
        bus.dir  = 1'b1;
        bus.mode = 1'b1;
        cyc();
        cycles(4);
        expect_out("auto_down_wrap", 6, 1, 1);
        cyc();
        expect_out("auto_down_after", 6, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
